// File: rtl/keypad_scan4x4_if.sv
// Keypad scanner bus: column sense and clear in, row drive plus accepted-key results out.
interface keypad_scan4x4_if;
  logic [3:0]  i_col;
  logic        i_clear;
  logic [3:0]  o_row;
  logic        o_key_valid;
  logic [3:0]  o_key_code;
  logic [31:0] o_data;

  modport master (
    output i_col,
    output i_clear,
    input  o_row,
    input  o_key_valid,
    input  o_key_code,
    input  o_data
  );

  modport slave (
    input  i_col,
    input  i_clear,
    output o_row,
    output o_key_valid,
    output o_key_code,
    output o_data
  );
endinterface

// File: rtl/keypad_scan4x4.sv
// 4x4 hex keypad scanner with press/release debounce and a 32-bit shift register of accepted codes.
// Optional macro KEYPAD_AUTOREPEAT_EN adds auto-repeat of a held key.
module keypad_scan4x4 #(
  parameter int SCAN_DIV       = 16384,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scan4x4_if.slave  bus
);

  localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    colMeta_q, colSync_q;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [4:0]    rep_q, rep_d;
`endif

  logic       tick;
  logic [3:0] colLow;
  logic       oneLow;
  logic       sameCol;
  logic [1:0] colEnc;
  logic [1:0] rowNext;
  logic       emit;
  logic [3:0] newCode;
  logic [31:0] dataBase;

  // Synchronizer, divider and all FSM/result registers share one async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      tick_q    <= '0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      cnt_q     <= 4'd0;
      valid_q   <= 1'b0;
      code_q    <= 4'd0;
      data_q    <= 32'd0;
      colMeta_q <= 4'hF;
      colSync_q <= 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      data_q    <= data_d;
      colMeta_q <= bus.i_col;
      colSync_q <= colMeta_q;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign tick    = (tick_q == TW'(SCAN_DIV - 1));
  assign colLow  = ~colSync_q;
  // Multi-key samples clear oneLow and are therefore handled exactly like no key.
  assign oneLow  = (colLow != 4'd0) && ((colLow & (colLow - 4'd1)) == 4'd0);
  assign sameCol = oneLow && (colEnc == col_q);
  assign rowNext = row_q + 2'd1;
  assign newCode = {row_q, colEnc};

  always_comb begin
    colEnc = 2'd0;
    case (colLow)
      4'b0010: colEnc = 2'd1;
      4'b0100: colEnc = 2'd2;
      4'b1000: colEnc = 2'd3;
      default: colEnc = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick ? '0 : tick_q + TW'(1);
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (oneLow) begin
            col_d = colEnc;
            cnt_d = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = PRESSED;
              emit    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = 5'd0;
`endif
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = rowNext;
          end
        end
        DEBOUNCE: begin
          if (sameCol) begin
            if ((cnt_q + 4'd1) == 4'(DEBOUNCE_SCANS)) begin
              state_d = PRESSED;
              emit    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = 5'd0;
`endif
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = SCAN;
            row_d   = rowNext;
          end
        end
        PRESSED: begin
          if (!oneLow) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = SCAN;
              row_d   = rowNext;
            end else begin
              state_d = RELEASE;
              cnt_d   = 4'd1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d = 5'd0;
          end else if (sameCol) begin
            // Fires on the 31st held tick; reload leaves 8 ticks until the next repeat.
            if (rep_q == 5'd30) begin
              emit  = 1'b1;
              rep_d = 5'd23;
            end else begin
              rep_d = rep_q + 5'd1;
            end
`endif
          end
        end
        RELEASE: begin
          if (oneLow) begin
            state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = 5'd0;
`endif
          end else if ((cnt_q + 4'd1) >= 4'(DEBOUNCE_SCANS)) begin
            state_d = SCAN;
            row_d   = rowNext;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  // A clear coinciding with an accept leaves only the new code in the register.
  always_comb begin
    dataBase = bus.i_clear ? 32'd0 : data_q;
    valid_d  = emit;
    code_d   = emit ? newCode : code_q;
    data_d   = emit ? {dataBase[27:0], newCode} : dataBase;
  end

  always_comb begin
    bus.o_row       = ~(4'b0001 << row_q);
    bus.o_key_valid = valid_q;
    bus.o_key_code  = code_q;
    bus.o_data      = data_q;
  end

endmodule
